// File: rtl/axi_rd_burst_splitter.sv
// axi_rd_burst_splitter
//
// Purpose: accepts one AXI4 read request at a time on the slave side. An INCR
// burst longer than MAX_BURST_LEN beats is issued on the master side as a
// series of shorter INCR bursts in address order. Any other request is
// forwarded unchanged as a single burst. Read data passes straight through.
// Intermediate RLASTs are hidden, so the slave side sees a single burst.
//
// Ports:
//   clk, rst          - single rising-edge clock, asynchronous active-high reset
//   s_axi_ar*         - slave-side read address channel (request in)
//   s_axi_r*          - slave-side read data channel (response out)
//   m_axi_ar*         - master-side read address channel (sub-bursts out)
//   m_axi_r*          - master-side read data channel (response in, RID ignored)
module axi_rd_burst_splitter #(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 64,
    parameter int ID_WIDTH      = 8,
    parameter int MAX_BURST_LEN = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ID_WIDTH-1:0]   s_axi_arid,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [7:0]            s_axi_arlen,
    input  logic [2:0]            s_axi_arsize,
    input  logic [1:0]            s_axi_arburst,
    input  logic                  s_axi_arlock,
    input  logic [3:0]            s_axi_arcache,
    input  logic [2:0]            s_axi_arprot,
    input  logic [3:0]            s_axi_arqos,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [ID_WIDTH-1:0]   s_axi_rid,
    output logic [DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rlast,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    output logic [ID_WIDTH-1:0]   m_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arlock,
    output logic [3:0]            m_axi_arcache,
    output logic [2:0]            m_axi_arprot,
    output logic [3:0]            m_axi_arqos,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;

    localparam int         LOG2_MAX  = $clog2(MAX_BURST_LEN);
    localparam logic [8:0] MAX_BEATS = 9'(MAX_BURST_LEN);

    logic [1:0]            state;
    logic [ID_WIDTH-1:0]   id_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] next_addr_q;
    logic [7:0]            len_q;
    logic [2:0]            size_q;
    logic [1:0]            burst_q;
    logic                  lock_q;
    logic [3:0]            cache_q;
    logic [2:0]            prot_q;
    logic [3:0]            qos_q;
    logic                  arvalid_q;
    // Beats not yet covered by an issued or currently presented sub-burst.
    logic [8:0]            rem_q;
    // Sub-burst count of the parent burst and R-side rlast count; 9 bits so
    // that 256 single-beat sub-bursts fit.
    logic [8:0]            num_sub_q;
    logic [8:0]            r_cnt_q;

    logic [8:0]            total_in;
    logic                  split_in;
    logic [8:0]            subs_in;
    logic [ADDR_WIDTH-1:0] next_in;
    logic [ADDR_WIDTH-1:0] step;
    logic [8:0]            chunk;
    logic                  ar_hs;
    logic                  rlast_hs;
    logic                  last_sub;
    logic                  final_rlast;
    logic                  r_done;

    // Request decode at capture time. MAX_BURST_LEN is a power of two, so the
    // ceiling divide becomes an add and a shift. Sub-burst 1 starts at the
    // size-aligned base plus one full stride.
    assign total_in = {1'b0, s_axi_arlen} + 9'd1;
    assign split_in = (s_axi_arburst == 2'b01) && (total_in > MAX_BEATS);
    assign subs_in  = split_in ? ((total_in + MAX_BEATS - 9'd1) >> LOG2_MAX) : 9'd1;
    assign next_in  = (s_axi_araddr & ({ADDR_WIDTH{1'b1}} << s_axi_arsize))
                    + (ADDR_WIDTH'(MAX_BURST_LEN) << s_axi_arsize);

    assign step  = ADDR_WIDTH'(MAX_BURST_LEN) << size_q;
    assign chunk = (rem_q >= MAX_BEATS) ? MAX_BEATS : rem_q;
    assign ar_hs = arvalid_q && m_axi_arready;

    // The R side is tracked independently of AR issue, so data for early
    // sub-bursts may return while later addresses are still stalled.
    // Stray beats in IDLE are not counted.
    assign rlast_hs    = m_axi_rvalid && s_axi_rready && m_axi_rlast && (state != IDLE);
    assign last_sub    = (r_cnt_q == num_sub_q - 9'd1);
    assign final_rlast = rlast_hs && last_sub;
    assign r_done      = (r_cnt_q == num_sub_q) || final_rlast;

    assign s_axi_arready = (state == IDLE);

    assign m_axi_arid    = id_q;
    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = len_q;
    assign m_axi_arsize  = size_q;
    assign m_axi_arburst = burst_q;
    assign m_axi_arlock  = lock_q;
    assign m_axi_arcache = cache_q;
    assign m_axi_arprot  = prot_q;
    assign m_axi_arqos   = qos_q;
    assign m_axi_arvalid = arvalid_q;

    assign s_axi_rid    = id_q;
    assign s_axi_rdata  = m_axi_rdata;
    assign s_axi_rresp  = m_axi_rresp;
    assign s_axi_rvalid = m_axi_rvalid;
    assign s_axi_rlast  = m_axi_rlast && last_sub;
    assign m_axi_rready = s_axi_rready;

    // The master AR payload registers always hold the sub-burst currently
    // presented. On each handshake the next sub-burst is loaded, so
    // back-to-back sub-bursts leave no idle cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            id_q        <= '0;
            addr_q      <= '0;
            next_addr_q <= '0;
            len_q       <= '0;
            size_q      <= '0;
            burst_q     <= '0;
            lock_q      <= 1'b0;
            cache_q     <= '0;
            prot_q      <= '0;
            qos_q       <= '0;
            arvalid_q   <= 1'b0;
            rem_q       <= '0;
            num_sub_q   <= '0;
            r_cnt_q     <= '0;
        end else begin
            if (rlast_hs) begin
                r_cnt_q <= r_cnt_q + 9'd1;
            end
            case (state)
                IDLE: begin
                    if (s_axi_arvalid) begin
                        id_q        <= s_axi_arid;
                        addr_q      <= s_axi_araddr;
                        next_addr_q <= next_in;
                        len_q       <= split_in ? 8'(MAX_BEATS - 9'd1) : s_axi_arlen;
                        size_q      <= s_axi_arsize;
                        burst_q     <= s_axi_arburst;
                        lock_q      <= s_axi_arlock;
                        cache_q     <= s_axi_arcache;
                        prot_q      <= s_axi_arprot;
                        qos_q       <= s_axi_arqos;
                        arvalid_q   <= 1'b1;
                        rem_q       <= split_in ? (total_in - MAX_BEATS) : 9'd0;
                        num_sub_q   <= subs_in;
                        r_cnt_q     <= '0;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (ar_hs) begin
                        if (rem_q == 9'd0) begin
                            arvalid_q <= 1'b0;
                            state     <= r_done ? IDLE : DRAIN;
                        end else begin
                            addr_q      <= next_addr_q;
                            next_addr_q <= next_addr_q + step;
                            len_q       <= 8'(chunk - 9'd1);
                            rem_q       <= rem_q - chunk;
                        end
                    end
                end
                DRAIN: begin
                    if (final_rlast) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/axi_rd_burst_splitter.md
AXI_RD_BURST_SPLITTER -- requirements
Module: axi_rd_burst_splitter

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, address width in bits.
REQ-002 Parameter DATA_WIDTH, default 64, R data width in bits, identical on both sides.
REQ-003 Parameter ID_WIDTH, default 8, AXI ID width.
REQ-004 Parameter MAX_BURST_LEN, default 16, maximum beats per master-side burst; power of two, 1..256.
REQ-005 clk  in  1  single clock; all logic rising-edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 s_axi_arid / s_axi_araddr  in  ID_WIDTH / ADDR_WIDTH  slave AR ID and address.
REQ-008 s_axi_arlen / s_axi_arsize / s_axi_arburst  in  8 / 3 / 2  slave AR length, size and burst type.
REQ-009 s_axi_arlock / arcache / arprot / arqos  in  1 / 4 / 3 / 4  slave AR sideband.
REQ-010 s_axi_arvalid in 1, s_axi_arready out 1  slave AR handshake.
REQ-011 s_axi_rid / s_axi_rdata / s_axi_rresp / s_axi_rlast  out  ID_WIDTH / DATA_WIDTH / 2 / 1  slave R payload.
REQ-012 s_axi_rvalid out 1, s_axi_rready in 1  slave R handshake.
REQ-013 m_axi_arid / araddr / arlen / arsize / arburst  out  ID_WIDTH / ADDR_WIDTH / 8 / 3 / 2  master AR payload.
REQ-014 m_axi_arlock / arcache / arprot / arqos  out  1 / 4 / 3 / 4  master AR sideband, copied from the captured slave request.
REQ-015 m_axi_arvalid out 1, m_axi_arready in 1  master AR handshake.
REQ-016 m_axi_rdata / m_axi_rresp / m_axi_rlast  in  DATA_WIDTH / 2 / 1  master R payload; m_axi_rid is ignored.
REQ-017 m_axi_rvalid in 1, m_axi_rready out 1  master R handshake.

Function
REQ-018 The block SHALL run a three-state FSM: IDLE, ISSUE, DRAIN; one parent burst in flight at a time.
REQ-019 In IDLE, s_axi_arready SHALL be 1; on s_axi_arvalid&&s_axi_arready the block SHALL register all AR fields and enter ISSUE next cycle.
REQ-020 Split condition: arburst==INCR (2'b01) and arlen+1 > MAX_BURST_LEN; otherwise the request SHALL be forwarded unchanged as one master burst.
REQ-021 Split bursts SHALL issue N = ceil((arlen+1)/MAX_BURST_LEN) sub-bursts, each with arlen = min(remaining beats, MAX_BURST_LEN)-1, in address order.
REQ-022 Sub-burst 0 SHALL use the original araddr; sub-burst k>0 SHALL use (araddr with low arsize bits cleared) + k*(MAX_BURST_LEN<<arsize), computed in ADDR_WIDTH bits, wrapping modulo 2^ADDR_WIDTH.
REQ-023 m_axi_arvalid SHALL be registered and stay asserted with stable payload until m_axi_arready; one sub-burst SHALL be issued per handshake, with no idle cycle between sub-bursts.
REQ-024 After the last AR handshake the FSM SHALL enter DRAIN; if all R beats have already returned, it SHALL return to IDLE directly.
REQ-025 R path SHALL be combinational pass-through: s_axi_rvalid=m_axi_rvalid, m_axi_rready=s_axi_rready, rdata and rresp forwarded per beat.
REQ-026 s_axi_rid SHALL equal the registered arid.
REQ-027 s_axi_rlast SHALL be m_axi_rlast AND (current R sub-burst is the last one); intermediate m_axi_rlast SHALL be suppressed.
REQ-028 An R-side sub-burst counter SHALL increment on each accepted m_axi_rlast beat, independently of AR issue, so R beats arriving during ISSUE are handled.
REQ-029 The FSM SHALL leave DRAIN for IDLE in the cycle after the final rlast handshake; the next AR may be accepted in that IDLE cycle.
REQ-030 m_axi_rvalid outside ISSUE/DRAIN is a protocol error; the block SHALL pass it through unchanged without changing state.
REQ-031 arlen=255 with MAX_BURST_LEN=1 SHALL yield 256 sub-bursts; the counters SHALL be wide enough to hold 256.

Reset
REQ-032 On rst, regardless of state or pending handshakes, the FSM SHALL enter IDLE, counters SHALL clear, m_axi_arvalid SHALL be 0, and registered AR fields SHALL be 0.
REQ-033 After rst deasserts, s_axi_arready SHALL be 1; in-flight R beats from before reset are not tracked.

Verification
REQ-034 MAX=16, araddr=0x1000, arlen=63, arsize=3, INCR -> 4 master ARs at 0x1000/0x1080/0x1100/0x1180, arlen=15 each; only the 64th R beat has s_axi_rlast=1.
REQ-035 arlen=19, MAX=16, araddr=0x2004, arsize=3 -> ARs 0x2004 len15, 0x2080 len3; s_axi_rid equals arid on all 20 beats.
REQ-036 WRAP burst, arlen=15 (and FIXED arlen=31) -> single unchanged master AR; rlast passed through.
REQ-037 m_axi_arready held 0 for 5 cycles mid-split -> arvalid and payload stable; s_axi_arready=0 until the final rlast; R beats for sub-burst 0 accepted during the stall.
REQ-038 s_axi_rready toggling randomly with rresp=SLVERR on beat 7 -> beat count preserved, SLVERR forwarded on beat 7 only.
REQ-039 rst asserted during DRAIN with rvalid high -> outputs reach reset values immediately; a new AR is accepted on the first cycle after rst deasserts.
